uart_tx_arbiter: RTL and testbench

//   Shares the single UART transmitter between NREQ byte producers, e.g. screen

---
 rtl/uart_tx_arbiter.sv | 175 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one UART transmitter between NREQ producers.
// A grant holder keeps the transmitter until it hands over a byte flagged last.
module uart_tx_arbiter #(
  parameter int unsigned NREQ     = 3,
  parameter int unsigned HOLD_MAX = 64,
  parameter int unsigned TX_TOUT  = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_byte,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   grant,
  output logic [7:0]        o_byte,
  output logic              o_byte_v,
  input  logic              i_tx_active,
  input  logic              i_tx_done,
  output logic              busy,
  output logic              err_tout
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam int unsigned WW = (TX_TOUT > 1) ? $clog2(TX_TOUT) : 1;

  typedef enum logic [1:0] {StIdle, StArm, StWait} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   rr_q, rr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [WW-1:0]   wdog_q, wdog_d;
  logic            last_q, last_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [7:0]      byte_q, byte_d;
  logic            byte_v_q, byte_v_d;
  logic [NREQ-1:0] ready_q, ready_d;
  logic            err_q, err_d;

  logic            pick_found;
  logic [PW-1:0]   pick_idx;
  logic [PW-1:0]   rr_next;

  // First valid requester searching upward from rr_q, wrapping at NREQ.
  always_comb begin
    int unsigned cand;
    logic [PW-1:0] cand_idx;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand     = (32'(rr_q) + k) % NREQ;
      cand_idx = PW'(cand);
      if (!pick_found && req_valid[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  assign rr_next = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + PW'(1);

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    owner_d  = owner_q;
    hold_d   = hold_q;
    wdog_d   = wdog_q;
    last_d   = last_q;
    grant_d  = grant_q;
    byte_d   = byte_q;
    byte_v_d = 1'b0;
    ready_d  = '0;
    err_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        hold_d = '0;
        wdog_d = '0;
        if (pick_found) begin
          grant_d = NREQ'(1) << pick_idx;
          owner_d = pick_idx;
          state_d = StArm;
        end
      end

      StArm: begin
        if (req_valid[owner_q] && !i_tx_active) begin
          byte_d   = req_byte[{owner_q, 3'b000} +: 8];
          byte_v_d = 1'b1;
          ready_d  = grant_q;
          last_d   = req_last[owner_q];
          hold_d   = '0;
          wdog_d   = '0;
          state_d  = StWait;
        end else if (hold_q == HW'(HOLD_MAX - 1)) begin
          // Holder stalled too long: revoke and move the rotation past it.
          err_d   = 1'b1;
          grant_d = '0;
          rr_d    = rr_next;
          hold_d  = '0;
          state_d = StIdle;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end

      StWait: begin
        // Done wins over a coincident watchdog expiry.
        if (i_tx_done) begin
          wdog_d = '0;
          hold_d = '0;
          if (last_q) begin
            grant_d = '0;
            rr_d    = rr_next;
            state_d = StIdle;
          end else begin
            state_d = StArm;
          end
        end else if (wdog_q == WW'(TX_TOUT - 1)) begin
          err_d   = 1'b1;
          wdog_d  = '0;
          grant_d = '0;
          rr_d    = rr_next;
          state_d = StIdle;
        end else begin
          wdog_d = wdog_q + WW'(1);
        end
      end

      default: begin
        grant_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      rr_q     <= '0;
      owner_q  <= '0;
      hold_q   <= '0;
      wdog_q   <= '0;
      last_q   <= 1'b0;
      grant_q  <= '0;
      byte_q   <= '0;
      byte_v_q <= 1'b0;
      ready_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      owner_q  <= owner_d;
      hold_q   <= hold_d;
      wdog_q   <= wdog_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      byte_q   <= byte_d;
      byte_v_q <= byte_v_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
    end
  end

  assign req_ready = ready_q;
  assign grant     = grant_q;
  assign o_byte    = byte_q;
  assign o_byte_v  = byte_v_q;
  assign err_tout  = err_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queued producers, a simple UART model and
// hand-computed expectations for ordering, timeouts and reset behaviour.
module tb_uart_tx_arbiter;

  localparam int unsigned NREQ     = 3;
  localparam int unsigned HOLD_MAX = 16;
  localparam int unsigned TX_TOUT  = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [23:0] req_byte;
  logic [2:0]  req_last;
  logic [2:0]  req_ready;
  logic [2:0]  grant;
  logic [7:0]  o_byte;
  logic        o_byte_v;
  logic        i_tx_active;
  logic        i_tx_done;
  logic        busy;
  logic        err_tout;

  uart_tx_arbiter #(
    .NREQ     (NREQ),
    .HOLD_MAX (HOLD_MAX),
    .TX_TOUT  (TX_TOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_byte    (req_byte),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .grant       (grant),
    .o_byte      (o_byte),
    .o_byte_v    (o_byte_v),
    .i_tx_active (i_tx_active),
    .i_tx_done   (i_tx_done),
    .busy        (busy),
    .err_tout    (err_tout)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Producer queues: {last, byte}; rd advances on req_ready.
  logic [8:0]  pkt [3][8];
  int unsigned len [3];
  int unsigned rd  [3];
  logic [2:0]  en;
  logic        tb_clr;
  logic        uart_en;
  logic        force_active;
  logic        stray_done;
  logic        done_model;
  logic        active_model;
  int          cnt;
  logic [7:0]  log_b [$];
  int          log_o [$];
  logic [2:0]  rdy_prev;
  int          rdy_dbl;
  int          rdy_cnt;

  for (genvar i = 0; i < 3; i++) begin : g_prod
    assign req_valid[i]       = en[i] && (rd[i] < len[i]);
    assign req_byte[8*i +: 8] = (rd[i] < len[i]) ? pkt[i][rd[i][2:0]][7:0] : 8'h00;
    assign req_last[i]        = (rd[i] < len[i]) ? pkt[i][rd[i][2:0]][8] : 1'b0;
  end

  assign i_tx_done   = done_model | stray_done;
  assign i_tx_active = active_model | force_active;

  function automatic int oh2idx(input logic [2:0] v);
    int r;
    r = -1;
    for (int i = 0; i < 3; i++) if (v[i]) r = i;
    return r;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (tb_clr) rd[i] <= 0;
      else if (req_ready[i]) rd[i] <= rd[i] + 1;
    end
    rdy_prev <= req_ready;
    if (|(req_ready & rdy_prev)) rdy_dbl <= rdy_dbl + 1;
    rdy_cnt <= tb_clr ? 0 : rdy_cnt + $countones(req_ready);
  end

  // UART model: done pulses four edges after the strobe is seen.
  always @(posedge clk) begin
    done_model <= 1'b0;
    if (rst) begin
      cnt          <= 0;
      active_model <= 1'b0;
    end else if (o_byte_v) begin
      log_b.push_back(o_byte);
      log_o.push_back(oh2idx(req_ready));
      if (uart_en) begin
        cnt          <= 3;
        active_model <= 1'b1;
      end
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        done_model   <= 1'b1;
        active_model <= 1'b0;
      end
    end
    if (tb_clr) begin
      log_b.delete();
      log_o.delete();
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input int r, input int idx, input logic [8:0] v);
    pkt[r][idx] = v;
  endtask

  task automatic clear_bench();
    tb_clr = 1'b1;
    step(1);
    tb_clr = 1'b0;
  endtask

  task automatic wait_log(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (log_b.size() < n && k < budget) begin
      step(1);
      k++;
    end
    check(tag, log_b.size(), n);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k;
    k = 0;
    while (busy && k < budget) begin
      step(1);
      k++;
    end
    check(tag, {31'b0, busy}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int k;
    for (int i = 0; i < 3; i++) begin
      len[i] = 0;
      for (int j = 0; j < 8; j++) pkt[i][j] = 9'h0;
    end
    rdy_dbl = 0;
    en = 3'b000; tb_clr = 1'b0; uart_en = 1'b1;
    force_active = 1'b0; stray_done = 1'b0;
    rst = 1'b1;
    step(1);
    check("reset_grant", grant, 0);
    check("reset_busy", {31'b0, busy}, 0);
    check("reset_strobe", {31'b0, o_byte_v}, 0);
    clear_bench();
    rst = 1'b0;

    // Escape sequence from req0 must not interleave with req1's byte.
    load(0, 0, {1'b0, 8'h1B}); load(0, 1, {1'b0, 8'h5B}); load(0, 2, {1'b1, 8'h48});
    len[0] = 3;
    load(1, 0, {1'b1, 8'h78}); len[1] = 1;
    len[2] = 0;
    en = 3'b011;
    wait_log(4, 200, "esc_count");
    check("esc_b0", log_b[0], 8'h1B);
    check("esc_b1", log_b[1], 8'h5B);
    check("esc_b2", log_b[2], 8'h48);
    check("esc_b3", log_b[3], 8'h78);
    check("esc_own2", log_o[2], 0);
    check("esc_own3", log_o[3], 1);
    wait_idle(50, "esc_idle");
    en = 3'b000;

    // Reset in WAIT; rr_ptr is 2 here so req1 alone is granted.
    clear_bench();
    load(1, 0, {1'b0, 8'hAA}); load(1, 1, {1'b0, 8'hBB}); len[1] = 2;
    len[0] = 0; len[2] = 0;
    uart_en = 1'b0;
    en = 3'b010;
    step(1);
    check("rst_pre_grant", grant, 3'b010);
    step(1);
    check("rst_pre_strobe", {31'b0, o_byte_v}, 1);
    check("rst_pre_byte", o_byte, 8'hAA);
    check("rst_pre_ready", req_ready, 3'b010);
    step(1);
    check("rst_pre_wait", {30'b0, busy, o_byte_v}, 2'b10);
    en = 3'b000;
    rst = 1'b1;
    step(1);
    check("rst_grant", grant, 0);
    check("rst_byte", o_byte, 0);
    check("rst_outs", {28'b0, busy, o_byte_v, err_tout, |req_ready}, 0);
    tb_clr = 1'b1;
    step(1);
    tb_clr = 1'b0;
    rst = 1'b0;

    // Continuous single-byte packets from all three requesters.
    for (int i = 0; i < 3; i++) begin
      load(i, 0, {1'b1, 8'(8'h10 + i)});
      load(i, 1, {1'b1, 8'(8'h13 + i)});
      len[i] = 2;
    end
    uart_en = 1'b1;
    en = 3'b111;
    step(1);
    check("rst_next_grant", grant, 3'b001);
    wait_log(6, 300, "rr_count");
    for (int i = 0; i < 6; i++) begin
      check($sformatf("rr_own%0d", i), log_o[i], i % 3);
      check($sformatf("rr_byte%0d", i), log_b[i], 8'h10 + i);
    end
    wait_idle(50, "rr_idle");
    check("rr_ready_cnt", rdy_cnt, 6);
    en = 3'b000;

    // req2 stalls after a non-last byte: grant revoked HOLD_MAX cycles after ARM entry.
    clear_bench();
    load(2, 0, {1'b0, 8'hC1}); load(2, 1, {1'b1, 8'hC2}); len[2] = 2;
    load(0, 0, {1'b1, 8'hD0}); len[0] = 1;
    len[1] = 0;
    en = 3'b100;
    step(1);
    check("hold_grant", grant, 3'b100);
    step(1);
    check("hold_strobe", {31'b0, o_byte_v}, 1);
    en = 3'b000;
    k = 0;
    while (!i_tx_done && k < 20) begin
      step(1);
      k++;
    end
    check("hold_done_seen", {31'b0, i_tx_done}, 1);
    step(1);
    step(HOLD_MAX - 1);
    check("hold_no_err_early", {31'b0, err_tout}, 0);
    check("hold_grant_kept", grant, 3'b100);
    step(1);
    check("hold_err", {31'b0, err_tout}, 1);
    check("hold_released", grant, 0);
    check("hold_busy", {31'b0, busy}, 0);
    en = 3'b101;
    step(1);
    check("hold_err_pulse", {31'b0, err_tout}, 0);
    check("hold_rr0", grant, 3'b001);
    wait_log(3, 200, "hold_count");
    check("hold_b1", log_b[1], 8'hD0);
    check("hold_b2", log_b[2], 8'hC2);
    wait_idle(50, "hold_idle");
    en = 3'b000;

    // No done after the strobe: watchdog fires TX_TOUT cycles into WAIT.
    clear_bench();
    load(0, 0, {1'b1, 8'hE0}); len[0] = 1;
    len[1] = 0; len[2] = 0;
    uart_en = 1'b0;
    en = 3'b001;
    step(1);
    check("tout_grant", grant, 3'b001);
    step(1);
    check("tout_strobe", {31'b0, o_byte_v}, 1);
    step(TX_TOUT - 1);
    check("tout_no_err_early", {30'b0, busy, err_tout}, 2'b10);
    step(1);
    check("tout_err", {31'b0, err_tout}, 1);
    check("tout_released", {29'b0, grant}, 0);
    check("tout_busy", {31'b0, busy}, 0);
    en = 3'b000;
    stray_done = 1'b1;
    step(1);
    stray_done = 1'b0;
    check("stray_outs", {28'b0, busy, o_byte_v, err_tout, |grant}, 0);
    step(1);
    check("stray_outs2", {28'b0, busy, o_byte_v, err_tout, |grant}, 0);

    // Transmitter busy while armed: strobe withheld until it drops.
    clear_bench();
    load(1, 0, {1'b1, 8'hF1}); len[1] = 1;
    len[0] = 0; len[2] = 0;
    uart_en = 1'b1;
    force_active = 1'b1;
    en = 3'b010;
    step(1);
    check("act_grant", grant, 3'b010);
    for (int i = 0; i < 10; i++) begin
      step(1);
      check($sformatf("act_hold%0d", i), {31'b0, o_byte_v}, 0);
    end
    force_active = 1'b0;
    step(1);
    check("act_strobe", {31'b0, o_byte_v}, 1);
    check("act_byte", o_byte, 8'hF1);
    step(1);
    check("act_strobe_end", {31'b0, o_byte_v}, 0);
    wait_idle(50, "act_idle");
    check("act_single", log_b.size(), 1);
    en = 3'b000;

    check("ready_single_cycle", rdy_dbl, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
